// File: rtl/impulse_response_capture.sv
// Captures a filter impulse response starting at its first nonzero sample,
// measures its effective length, checks it for symmetry and offers it for readout.
module impulse_response_capture #(
  parameter int DATA_W      = 18,
  parameter int CAPTURE_LEN = 64,
  parameter int LEN_W       = 7
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic [DATA_W-1:0] Data_i,
  input  logic              DataValid_i,
  input  logic              Arm_i,
  input  logic              RdReq_i,
  output logic [DATA_W-1:0] Data_o,
  output logic              DataValid_o,
  output logic              Done_o,
  output logic              Symmetric_o,
  output logic [LEN_W-1:0]  Length_o
);
  localparam int AW = $clog2(CAPTURE_LEN);

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, CHECK, DONE} state_t;

  state_t                   state_q;
  logic signed [DATA_W-1:0] buf_q [CAPTURE_LEN];
  logic [AW-1:0]            wcnt_q;
  logic [AW-1:0]            lastnz_q;
  logic [AW-1:0]            chk_q;
  logic [LEN_W-1:0]         len_q;
  logic                     flag_q;
  logic [LEN_W-1:0]         rptr_q;
  logic [DATA_W-1:0]        data_q;
  logic                     dvld_q;
  logic                     done_q;
  logic                     sym_q;
  logic [LEN_W-1:0]         leno_q;

  logic                     data_nz;
  logic                     we_d;
  logic [AW-1:0]            waddr_d;
  logic [AW-1:0]            mir;
  logic                     mismatch;
  logic [LEN_W-1:0]         half_len;
  logic [LEN_W-1:0]         last_cmp;

  assign data_nz  = (Data_i != '0);
  // Modulo-2^AW arithmetic keeps len-1 correct even when len equals CAPTURE_LEN.
  assign mir      = len_q[AW-1:0] - AW'(1) - chk_q;
  assign mismatch = (buf_q[chk_q] != buf_q[mir]);
  assign half_len = len_q >> 1;
  assign last_cmp = (half_len <= LEN_W'(1)) ? '0 : half_len - LEN_W'(1);

  always_comb begin
    we_d    = 1'b0;
    waddr_d = wcnt_q;
    if (!Arm_i && DataValid_i) begin
      if (state_q == ARMED && data_nz) begin
        we_d    = 1'b1;
        waddr_d = '0;
      end else if (state_q == CAPTURE) begin
        we_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_i) begin
    if (we_d) buf_q[waddr_d] <= Data_i;
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      lastnz_q <= '0;
      chk_q    <= '0;
      len_q    <= '0;
      flag_q   <= 1'b0;
      rptr_q   <= '0;
      data_q   <= '0;
      dvld_q   <= 1'b0;
      done_q   <= 1'b0;
      sym_q    <= 1'b0;
      leno_q   <= '0;
    end else begin
      dvld_q <= 1'b0;
      if (Arm_i) begin
        state_q <= ARMED;
        done_q  <= 1'b0;
        sym_q   <= 1'b0;
        leno_q  <= '0;
        wcnt_q  <= '0;
        rptr_q  <= '0;
      end else begin
        case (state_q)
          ARMED: begin
            if (DataValid_i && data_nz) begin
              lastnz_q <= '0;
              wcnt_q   <= AW'(1);
              state_q  <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (DataValid_i) begin
              if (data_nz) lastnz_q <= wcnt_q;
              if (wcnt_q == AW'(CAPTURE_LEN - 1)) begin
                len_q   <= LEN_W'(data_nz ? wcnt_q : lastnz_q) + LEN_W'(1);
                chk_q   <= '0;
                flag_q  <= 1'b1;
                state_q <= CHECK;
              end else begin
                wcnt_q <= wcnt_q + AW'(1);
              end
            end
          end
          CHECK: begin
            if (mismatch) flag_q <= 1'b0;
            if (LEN_W'(chk_q) == last_cmp) begin
              done_q  <= 1'b1;
              sym_q   <= flag_q & ~mismatch;
              leno_q  <= len_q;
              state_q <= DONE;
            end else begin
              chk_q <= chk_q + AW'(1);
            end
          end
          DONE: begin
            if (RdReq_i && (rptr_q < leno_q)) begin
              data_q <= buf_q[rptr_q[AW-1:0]];
              dvld_q <= 1'b1;
              rptr_q <= rptr_q + LEN_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign Data_o      = data_q;
  assign DataValid_o = dvld_q;
  assign Done_o      = done_q;
  assign Symmetric_o = sym_q;
  assign Length_o    = leno_q;
endmodule
